// File: rtl/byte_encode_stream_if.sv
// byte_encode_stream_if: coefficient-in / byte-out handshake bundle for the ByteEncode_d stage
interface byte_encode_stream_if #(parameter int D_MAX = 12);
  logic             start;
  logic [3:0]       d;
  logic             coef_valid;
  logic             coef_ready;
  logic [D_MAX-1:0] coef;
  logic             byte_valid;
  logic             byte_ready;
  logic [7:0]       byte_data;
  logic             busy;
  logic             done;
  logic             err;
  modport master (output start, d, coef_valid, coef, byte_ready,
                  input  coef_ready, byte_valid, byte_data, busy, done, err);
  modport slave  (input  start, d, coef_valid, coef, byte_ready,
                  output coef_ready, byte_valid, byte_data, busy, done, err);
endinterface

// File: rtl/byte_encode_stream.sv
// byte_encode_stream: packs the low d bits of 256 coefficients LSB-first into a byte stream
module byte_encode_stream (
  input  logic                 clk,
  input  logic                 rst,
  byte_encode_stream_if.slave  bus
);
  localparam int N = 256;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  d_q, d_d;
  logic [19:0] buf_q, buf_d;
  logic [4:0]  bc_q, bc_d;
  logic [8:0]  cc_q, cc_d;
  logic        err_q, err_d;
  logic        run, coef_acc, byte_acc, d_ok;
  logic [19:0] mask;
  assign run            = state_q == RUN;
  assign bus.coef_ready = run && !cc_q[8] && bc_q < 5'd8;
  assign bus.byte_valid = run && bc_q >= 5'd8;
  assign bus.byte_data  = buf_q[7:0];
  assign bus.busy       = run;
  assign bus.done       = state_q == DONE;
  assign bus.err        = err_q;
  assign coef_acc       = bus.coef_valid && bus.coef_ready;
  assign byte_acc       = bus.byte_valid && bus.byte_ready;
  assign d_ok           = bus.d != 4'd0 && bus.d <= 4'd12;
  assign mask           = (20'd1 << d_q) - 20'd1;
  // bits at and above bc are always zero, so OR-ing the shifted coefficient places it at buf[bc +: d]
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    buf_d   = buf_q;
    bc_d    = bc_q;
    cc_d    = cc_q;
    err_d   = 1'b0;
    if (state_q == IDLE && bus.start) begin
      err_d = !d_ok;
      if (d_ok) begin
        state_d = RUN;
        d_d     = bus.d;
        buf_d   = '0;
        bc_d    = '0;
        cc_d    = '0;
      end
    end else if (run) begin
      if (coef_acc) begin
        buf_d = buf_q | ((20'(bus.coef) & mask) << bc_q);
        bc_d  = bc_q + 5'(d_q);
        cc_d  = cc_q + 9'd1;
      end else if (byte_acc) begin
        buf_d = buf_q >> 8;
        bc_d  = bc_q - 5'd8;
      end
      state_d = (cc_d == 9'(N) && bc_d == 5'd0) ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      buf_q   <= '0;
      bc_q    <= '0;
      cc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      buf_q   <= buf_d;
      bc_q    <= bc_d;
      cc_q    <= cc_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: doc/byte_encode_stream.md
# byte_encode_stream

Streaming ByteEncode_d stage for the Kyber datapath. It accepts 256 polynomial coefficients, one per handshake. It keeps only the low `d` bits of each coefficient and concatenates them LSB-first into a continuous bit stream. It then emits that stream as bytes, byte j holding stream bits 8j..8j+7 with bit 0 as the LSB. It sits directly upstream of the byte-array consumers (hash/serialiser) and produces the same bit-to-byte ordering as the combinational bits-to-bytes packer, without ever materialising the full 256·d-bit array.

## Interface
- `N`, 256, coefficients per polynomial.
- `D_MAX`, 12, maximum encode width; the coefficient port is `D_MAX` bits wide.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin encoding one polynomial; sampled only in IDLE.
- `d` input 4: encode width, legal range 1..12; latched on accepted `start`.
- `coef_valid` input 1: coefficient available.
- `coef_ready` output 1: block accepts a coefficient this cycle.
- `coef` input D_MAX: coefficient; bits above `d` are ignored.
- `byte_valid` output 1: output byte available.
- `byte_ready` input 1: downstream accepts the byte.
- `byte_data` output 8: output byte.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse after the last byte is accepted.
- `err` output 1: one-cycle pulse when `start` arrives in IDLE with an illegal `d`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 with 1≤`d`≤12: latch `d`, clear all counters and the buffer, go to RUN.
  - `start` with `d`=0 or `d`>12: stay in IDLE and pulse `err`.
- RUN datapath:
  - 20-bit bit buffer `buf` and a 5-bit fill count `bc`.
  - 9-bit coefficient counter `cc`.
- Coefficient accept (`coef_valid && coef_ready`):
  - `buf[bc +: d] <= coef & ((1<<d)-1)`, `bc <= bc + d`, `cc <= cc + 1`.
- Byte output:
  - `byte_valid = (bc >= 8)`, `byte_data = buf[7:0]`.
  - On `byte_valid && byte_ready`: `buf <= buf >> 8`, `bc <= bc - 8`.
- `coef_ready = RUN && cc < N && bc < 8`.
  - Because `coef_ready` requires `bc < 8`, an accept and an emit never occur in the same cycle.
  - Maximum fill is 7+12 = 19 bits, so the 20-bit buffer never overflows.
- `coef_ready` and `byte_valid` are decoded from registers only; neither depends combinationally on `coef_valid` or `byte_ready`.
- While `byte_valid=1 && byte_ready=0`, `byte_data` holds stable.
- Exit from RUN:
  - When `cc == N` and `bc == 0`, go to DONE. Since 256·d is divisible by 8, no partial byte remains.
  - DONE lasts one cycle: `done`=1, then return to IDLE.
- Total bytes emitted per polynomial = 32·d.
- `start` in RUN or DONE is ignored. `d` changes after start have no effect.
- Reset, including mid-operation: the state returns to IDLE immediately and all progress is discarded, with no partial output afterwards.

## Timing
- Reset values:
  - State IDLE.
  - `coef_ready`, `byte_valid`, `busy`, `done`, `err` all 0.
  - `byte_data` = 0x00, `buf`/`bc`/`cc` = 0.
- `start` accepted at edge k:
  - `busy`=1 and `coef_ready`=1 from cycle k+1.
- Coefficient accepted at edge m with resulting `bc ≥ 8`:
  - `byte_valid`=1 in cycle m+1.
- Last byte accepted at edge p:
  - `done`=1 in cycle p+1, `busy`=0 from cycle p+1, IDLE in cycle p+2.
  - A new `start` is accepted from cycle p+2.
- `err` is asserted in the cycle after the illegal `start` edge.
- Throughput with both sides always ready:
  - d=8: one coefficient and one byte per 2 cycles.
  - d=12: 3 bytes per 2 coefficients over 5 cycles.
- Source-side rule: `coef` and `coef_valid` must be held until accepted. The block tolerates `coef_valid` toggling.

## Test plan
- d=1, coef i = i%2, both sides always ready → 32 bytes, all 0xAA; `done` pulses once; exactly 32 byte handshakes.
- d=12, first coefficients 0x123, 0x456 → first bytes 0x23, 0x61, 0x45; 384 bytes total; the full stream matches a reference ByteEncode_12 over random coefficients < 3329.
- d=4, coefficients 0xFFF, 0x000 repeated → every byte 0x0F (upper bits masked); 128 bytes.
- Backpressure with d=10: `byte_ready` low for 5 cycles at byte 3 → `byte_data` is stable and `coef_ready` stays low; the output stream is identical to the no-backpressure run.
- Assert `rst` after 100 coefficients → all outputs return to reset values immediately. A new `start` with d=5 then yields a correct 160-byte stream.
- `start` with d=0, then d=13 → `err` pulses each time, `busy` stays 0, no bytes emitted. `start` during RUN → ignored, byte count unchanged.
